// File: rtl/isu_timing_issuer_pkg.sv
// Shared types for the DRAM issue stage: scheduler command encoding, issuer
// bank state, and timer slot indices.
package isu_timing_issuer_pkg;

   typedef enum logic [2:0] {
      ATCMD_NOP       = 3'd0,
      ATCMD_ACTIVE    = 3'd1,
      ATCMD_READ      = 3'd2,
      ATCMD_WRITE     = 3'd3,
      ATCMD_PRECHARGE = 3'd4,
      ATCMD_REFRESH   = 3'd5
   } sch_cmd_t;

   typedef enum logic [1:0] {
      ISS_CLOSED,
      ISS_OPEN,
      ISS_REFRESHING
   } issuer_state_t;

   localparam int CMD_W   = 3;
   localparam int NUM_TMR = 9;

   localparam int TI_RCD = 0;
   localparam int TI_RAS = 1;
   localparam int TI_RP  = 2;
   localparam int TI_CCD = 3;
   localparam int TI_WTR = 4;
   localparam int TI_RTW = 5;
   localparam int TI_RTP = 6;
   localparam int TI_WTP = 7;
   localparam int TI_RFC = 8;

   function automatic int isu_fifo_width(input int addr_w, input int ba_w);
      return CMD_W + addr_w + ba_w;
   endfunction

endpackage

// File: rtl/isu_sync_fifo.sv
// Single-clock FIFO with a combinational head read so the issuer can decide
// on the head entry in the same cycle it becomes visible.
module isu_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 20
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= wdata;
   end

   // Power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign rdata = mem[rd_ptr_reg];
   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/isu_timing_issuer.sv
// DRAM issue stage: queues scheduled commands and releases them in order,
// one per cycle, once every timing constraint and bank-state rule is met.
module isu_timing_issuer
   import isu_timing_issuer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 14,
   parameter int BA_W   = 3,
   parameter int TRCD   = 4,
   parameter int TRP    = 4,
   parameter int TRAS   = 10,
   parameter int TCCD   = 2,
   parameter int TWTR   = 6,
   parameter int TRTW   = 4,
   parameter int TRTP   = 3,
   parameter int TWTP   = 8,
   parameter int TRFC   = 30
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [CMD_W+ADDR_W+BA_W-1:0]  sch_out,
   input  logic                          sch_issue,
   output logic                          isu_fifo_full,
   output logic [CMD_W-1:0]              dram_cmd,
   output logic [ADDR_W-1:0]             dram_addr,
   output logic [BA_W-1:0]               dram_bank,
   output logic                          dram_cmd_valid,
   output logic                          bank_open,
   output logic                          proto_err,
   output logic                          ovf_err
);

   localparam int ISU_FIFO_WIDTH = isu_fifo_width(ADDR_W, BA_W);
   localparam int CNT_W          = $clog2(DEPTH) + 1;
   localparam int TMR_VAL [NUM_TMR] = '{TRCD, TRAS, TRP, TCCD, TWTR, TRTW, TRTP, TWTP, TRFC};

   logic [ISU_FIFO_WIDTH-1:0] fifo_rdata;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [CNT_W-1:0]          fifo_count;
   logic                      push_ok;
   logic                      pop;

   logic [CMD_W-1:0]          head_cmd;
   logic [ADDR_W-1:0]         head_addr;
   logic [BA_W-1:0]           head_bank;
   logic                      can_pop;
   logic                      legal;
   logic                      ready;
   logic                      silent;
   logic                      issue;
   logic                      illegal;

   logic [NUM_TMR-1:0]        tmr_start;
   logic [NUM_TMR-1:0]        tmr_zero;
   logic                      rfc_expiring;

   issuer_state_t             state_reg, state_next;
   logic [CMD_W-1:0]          dram_cmd_reg;
   logic [ADDR_W-1:0]         dram_addr_reg;
   logic [BA_W-1:0]           dram_bank_reg;
   logic                      dram_cmd_valid_reg;
   logic                      proto_err_reg;
   logic                      ovf_err_reg;

   // A push into a full queue is only accepted when the head leaves the same cycle.
   assign push_ok = sch_issue && ((fifo_count < CNT_W'(DEPTH)) || pop);

   isu_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ISU_FIFO_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_ok),
      .wdata (sch_out),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign head_cmd  = fifo_rdata[ISU_FIFO_WIDTH-1 -: CMD_W];
   assign head_addr = fifo_rdata[BA_W +: ADDR_W];
   assign head_bank = fifo_rdata[BA_W-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TMR; gi++) begin : g_tmr
         logic [7:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (!rst_n)                cnt_reg <= '0;
            else if (tmr_start[gi])    cnt_reg <= 8'(TMR_VAL[gi] - 1);
            else if (cnt_reg != 8'd0)  cnt_reg <= cnt_reg - 8'd1;
         end
         assign tmr_zero[gi] = (cnt_reg == 8'd0);
      end
   endgenerate

   // Leaving REFRESHING one edge early lets a queued command issue exactly tRFC after REFRESH.
   assign rfc_expiring = (g_tmr[TI_RFC].cnt_reg <= 8'd1);

   always_comb begin
      legal   = 1'b0;
      ready   = 1'b0;
      silent  = 1'b0;
      case (head_cmd)
         ATCMD_ACTIVE: begin
            legal = (state_reg == ISS_CLOSED);
            ready = tmr_zero[TI_RP] && tmr_zero[TI_RFC];
         end
         ATCMD_READ: begin
            legal = (state_reg == ISS_OPEN);
            ready = tmr_zero[TI_RCD] && tmr_zero[TI_CCD] && tmr_zero[TI_WTR] && tmr_zero[TI_RFC];
         end
         ATCMD_WRITE: begin
            legal = (state_reg == ISS_OPEN);
            ready = tmr_zero[TI_RCD] && tmr_zero[TI_CCD] && tmr_zero[TI_RTW] && tmr_zero[TI_RFC];
         end
         ATCMD_PRECHARGE: begin
            legal = 1'b1;
            ready = tmr_zero[TI_RAS] && tmr_zero[TI_RTP] && tmr_zero[TI_WTP] && tmr_zero[TI_RFC];
         end
         ATCMD_REFRESH: begin
            legal = (state_reg == ISS_CLOSED);
            ready = tmr_zero[TI_RP] && tmr_zero[TI_RFC];
         end
         default: silent = 1'b1;
      endcase

      can_pop = !fifo_empty && (state_reg != ISS_REFRESHING);
      issue   = can_pop && legal && ready;
      illegal = can_pop && !silent && !legal;
      pop     = issue || illegal || (can_pop && silent);

      tmr_start = '0;
      if (issue) begin
         case (head_cmd)
            ATCMD_ACTIVE:    begin tmr_start[TI_RCD] = 1'b1; tmr_start[TI_RAS] = 1'b1; end
            ATCMD_READ:      begin
               tmr_start[TI_CCD] = 1'b1;
               tmr_start[TI_RTW] = 1'b1;
               tmr_start[TI_RTP] = 1'b1;
            end
            ATCMD_WRITE:     begin
               tmr_start[TI_CCD] = 1'b1;
               tmr_start[TI_WTR] = 1'b1;
               tmr_start[TI_WTP] = 1'b1;
            end
            ATCMD_PRECHARGE: tmr_start[TI_RP]  = 1'b1;
            ATCMD_REFRESH:   tmr_start[TI_RFC] = 1'b1;
            default:         tmr_start = '0;
         endcase
      end

      state_next = state_reg;
      case (state_reg)
         ISS_CLOSED: begin
            if (issue && head_cmd == ATCMD_ACTIVE)       state_next = ISS_OPEN;
            else if (issue && head_cmd == ATCMD_REFRESH) state_next = ISS_REFRESHING;
         end
         ISS_OPEN: begin
            if (issue && head_cmd == ATCMD_PRECHARGE)    state_next = ISS_CLOSED;
         end
         ISS_REFRESHING: begin
            if (rfc_expiring)                            state_next = ISS_CLOSED;
         end
         default: state_next = ISS_CLOSED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg          <= ISS_CLOSED;
         dram_cmd_reg       <= ATCMD_NOP;
         dram_addr_reg      <= '0;
         dram_bank_reg      <= '0;
         dram_cmd_valid_reg <= 1'b0;
         proto_err_reg      <= 1'b0;
         ovf_err_reg        <= 1'b0;
      end else begin
         state_reg          <= state_next;
         dram_cmd_reg       <= issue ? head_cmd  : ATCMD_NOP;
         dram_addr_reg      <= issue ? head_addr : '0;
         dram_bank_reg      <= issue ? head_bank : '0;
         dram_cmd_valid_reg <= issue;
         proto_err_reg      <= proto_err_reg || illegal;
         ovf_err_reg        <= ovf_err_reg || (sch_issue && !push_ok);
      end
   end

   assign isu_fifo_full  = fifo_full;
   assign dram_cmd       = dram_cmd_reg;
   assign dram_addr      = dram_addr_reg;
   assign dram_bank      = dram_bank_reg;
   assign dram_cmd_valid = dram_cmd_valid_reg;
   assign bank_open      = (state_reg == ISS_OPEN);
   assign proto_err      = proto_err_reg;
   assign ovf_err        = ovf_err_reg;

endmodule

// File: tb/tb_isu_timing_issuer.sv
// Directed bench for isu_timing_issuer: timing gaps, bank-state rules,
// queue overflow and mid-operation reset, each scenario checked inline.
module tb_isu_timing_issuer;

   localparam logic [2:0] C_NOP = 3'd0;
   localparam logic [2:0] C_ACT = 3'd1;
   localparam logic [2:0] C_RD  = 3'd2;
   localparam logic [2:0] C_WR  = 3'd3;
   localparam logic [2:0] C_PRE = 3'd4;
   localparam logic [2:0] C_REF = 3'd5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] sch_out;
   logic        sch_issue;
   logic        isu_fifo_full;
   logic [2:0]  dram_cmd;
   logic [13:0] dram_addr;
   logic [2:0]  dram_bank;
   logic        dram_cmd_valid;
   logic        bank_open;
   logic        proto_err;
   logic        ovf_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   isu_timing_issuer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sch_out        (sch_out),
      .sch_issue      (sch_issue),
      .isu_fifo_full  (isu_fifo_full),
      .dram_cmd       (dram_cmd),
      .dram_addr      (dram_addr),
      .dram_bank      (dram_bank),
      .dram_cmd_valid (dram_cmd_valid),
      .bank_open      (bank_open),
      .proto_err      (proto_err),
      .ovf_err        (ovf_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] c, input logic [13:0] a, input logic [2:0] b);
      sch_out   = {c, a, b};
      sch_issue = 1'b1;
      $display("push cmd=%0d addr=%0d bank=%0d t=%0t", c, a, b, $time);
   endtask

   task automatic idle();
      sch_issue = 1'b0;
      sch_out   = '0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      tick();
      tick();
      checks++; if (dram_cmd !== C_NOP) begin errors++; $display("FAIL reset_cmd got %0d want %0d", dram_cmd, C_NOP); end
      checks++; if (dram_cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", dram_cmd_valid); end
      checks++; if (dram_addr !== 14'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", dram_addr); end
      checks++; if (bank_open !== 1'b0) begin errors++; $display("FAIL reset_bank_open got %0b want 0", bank_open); end
      checks++; if (isu_fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", isu_fifo_full); end
      checks++; if ({proto_err, ovf_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got %b want 00", {proto_err, ovf_err}); end
      rst_n = 1'b1;
   endtask

   task automatic test_act_read();
      logic [2:0] exp;
      do_reset();
      drive(C_ACT, 14'd5, 3'd1);
      tick();
      drive(C_RD, 14'd6, 3'd1);
      tick();
      checks++; if (dram_cmd !== C_ACT || dram_cmd_valid !== 1'b1) begin errors++; $display("FAIL act_issue got cmd=%0d v=%0b want %0d v=1", dram_cmd, dram_cmd_valid, C_ACT); end
      checks++; if (dram_addr !== 14'd5 || dram_bank !== 3'd1) begin errors++; $display("FAIL act_addr got %0d/%0d want 5/1", dram_addr, dram_bank); end
      idle();
      for (int j = 1; j <= 4; j++) begin
         tick();
         exp = (j == 4) ? C_RD : C_NOP;
         checks++; if (dram_cmd !== exp) begin errors++; $display("FAIL act_read_k+%0d got %0d want %0d", j, dram_cmd, exp); end
      end
      checks++; if (bank_open !== 1'b1) begin errors++; $display("FAIL act_read_open got %0b want 1", bank_open); end
   endtask

   task automatic test_act_wr_pre();
      logic [2:0] exp;
      do_reset();
      drive(C_ACT, 14'd3, 3'd0);
      tick();
      drive(C_WR, 14'd4, 3'd0);
      tick();
      checks++; if (dram_cmd !== C_ACT) begin errors++; $display("FAIL awp_act got %0d want %0d", dram_cmd, C_ACT); end
      drive(C_PRE, 14'd0, 3'd0);
      tick();
      checks++; if (dram_cmd !== C_NOP) begin errors++; $display("FAIL awp_k+1 got %0d want %0d", dram_cmd, C_NOP); end
      idle();
      for (int j = 2; j <= 12; j++) begin
         tick();
         exp = (j == 4) ? C_WR : ((j == 12) ? C_PRE : C_NOP);
         checks++; if (dram_cmd !== exp) begin errors++; $display("FAIL awp_k+%0d got %0d want %0d", j, dram_cmd, exp); end
      end
      checks++; if (bank_open !== 1'b0) begin errors++; $display("FAIL awp_closed got %0b want 0", bank_open); end
   endtask

   task automatic test_overflow();
      int n;
      int first;
      do_reset();
      drive(C_REF, 14'd0, 3'd0);
      tick();
      idle();
      tick();
      checks++; if (dram_cmd !== C_REF) begin errors++; $display("FAIL ovf_ref got %0d want %0d", dram_cmd, C_REF); end
      for (int i = 1; i <= 9; i++) begin
         drive(C_PRE, 14'(i), 3'd0);
         tick();
         if (i == 7) begin
            checks++; if (isu_fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_full7 got %0b want 0", isu_fifo_full); end
         end
         if (i == 8) begin
            checks++; if (isu_fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full8 got %0b want 1", isu_fifo_full); end
            checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_err8 got %0b want 0", ovf_err); end
         end
         if (i == 9) begin
            checks++; if (isu_fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full9 got %0b want 1", isu_fifo_full); end
            checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_err9 got %0b want 1", ovf_err); end
         end
      end
      idle();
      n = 0;
      first = -1;
      for (int j = 10; j <= 45; j++) begin
         tick();
         if (dram_cmd_valid === 1'b1) begin
            if (first < 0) first = j;
            n++;
            checks++; if (dram_cmd !== C_PRE || dram_addr !== 14'(n)) begin errors++; $display("FAIL ovf_drain%0d got %0d/%0d want %0d/%0d", n, dram_cmd, dram_addr, C_PRE, n); end
         end
      end
      checks++; if (n != 8) begin errors++; $display("FAIL ovf_count got %0d want 8", n); end
      checks++; if (first != 30) begin errors++; $display("FAIL ovf_first_pop got k+%0d want k+30", first); end
   endtask

   task automatic test_illegal_read();
      do_reset();
      drive(C_RD, 14'd1, 3'd0);
      tick();
      checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ill_pre got %0b want 0", proto_err); end
      drive(C_ACT, 14'd2, 3'd0);
      tick();
      checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL ill_proto got %0b want 1", proto_err); end
      checks++; if (dram_cmd !== C_NOP || dram_cmd_valid !== 1'b0) begin errors++; $display("FAIL ill_nop got %0d v=%0b want %0d v=0", dram_cmd, dram_cmd_valid, C_NOP); end
      idle();
      tick();
      checks++; if (dram_cmd !== C_ACT || dram_addr !== 14'd2) begin errors++; $display("FAIL ill_next_act got %0d/%0d want %0d/2", dram_cmd, dram_addr, C_ACT); end
   endtask

   task automatic test_refresh_act();
      logic [2:0] exp;
      do_reset();
      drive(C_REF, 14'd0, 3'd0);
      tick();
      drive(C_ACT, 14'd9, 3'd2);
      tick();
      checks++; if (dram_cmd !== C_REF) begin errors++; $display("FAIL ref_issue got %0d want %0d", dram_cmd, C_REF); end
      idle();
      for (int j = 1; j <= 30; j++) begin
         tick();
         exp = (j == 30) ? C_ACT : C_NOP;
         checks++; if (dram_cmd !== exp) begin errors++; $display("FAIL ref_k+%0d got %0d want %0d", j, dram_cmd, exp); end
         if (j == 29) begin
            checks++; if (bank_open !== 1'b0) begin errors++; $display("FAIL ref_open29 got %0b want 0", bank_open); end
         end
         if (j == 30) begin
            checks++; if (bank_open !== 1'b1 || dram_bank !== 3'd2) begin errors++; $display("FAIL ref_open30 got %0b/%0d want 1/2", bank_open, dram_bank); end
         end
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      drive(C_ACT, 14'd1, 3'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(C_PRE, 14'(11 + i), 3'd0);
         tick();
      end
      checks++; if (bank_open !== 1'b1) begin errors++; $display("FAIL mid_open got %0b want 1", bank_open); end
      idle();
      rst_n = 1'b0;
      tick();
      checks++; if (dram_cmd !== C_NOP || dram_cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_cmd got %0d v=%0b want 0 v=0", dram_cmd, dram_cmd_valid); end
      checks++; if (dram_addr !== 14'd0 || dram_bank !== 3'd0) begin errors++; $display("FAIL mid_rst_addr got %0d/%0d want 0/0", dram_addr, dram_bank); end
      checks++; if ({bank_open, isu_fifo_full, proto_err, ovf_err} !== 4'b0000) begin errors++; $display("FAIL mid_rst_flags got %b want 0000", {bank_open, isu_fifo_full, proto_err, ovf_err}); end
      rst_n = 1'b1;
      drive(C_ACT, 14'd7, 3'd2);
      tick();
      checks++; if (dram_cmd !== C_NOP) begin errors++; $display("FAIL mid_push_edge got %0d want %0d", dram_cmd, C_NOP); end
      idle();
      tick();
      checks++; if (dram_cmd !== C_ACT || dram_addr !== 14'd7 || dram_bank !== 3'd2) begin errors++; $display("FAIL mid_fresh_act got %0d/%0d/%0d want %0d/7/2", dram_cmd, dram_addr, dram_bank, C_ACT); end
      for (int j = 0; j < 12; j++) begin
         tick();
         checks++; if (dram_cmd_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got cmd=%0d addr=%0d want none", j, dram_cmd, dram_addr); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      sch_issue = 1'b0;
      sch_out   = '0;
      test_reset();
      test_act_read();
      test_act_wr_pre();
      test_overflow();
      test_illegal_read();
      test_refresh_act();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/isu_timing_issuer.md
Name: isu_timing_issuer

Overview:
- Issue stage directly downstream of the command scheduler.
- Buffers scheduled {cmd, addr, bank} words in an issue FIFO and back-pressures the scheduler via isu_fifo_full.
- Pops and drives one DRAM command per cycle only when every JEDEC-style timing constraint for that command is met.
- Tracks single-bank open/closed state, so illegal sequences are caught before reaching the device.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, >=2)
- ADDR_W, 14, address field width (= ADDR_BITS)
- BA_W, 3, bank field width (= BA_BITS)
- TRCD, 4, ACT to READ/WRITE, cycles
- TRP, 4, PRE to ACT/REFRESH
- TRAS, 10, ACT to PRE
- TCCD, 2, column to column
- TWTR, 6, WRITE to READ
- TRTW, 4, READ to WRITE
- TRTP, 3, READ to PRE
- TWTP, 8, WRITE to PRE (write latency + burst + tWR)
- TRFC, 30, REFRESH to any command
- All timing parameters are 1..255.

Ports:
- clk in 1: clock
- rst_n in 1: synchronous active-low reset
- sch_out in 3+ADDR_W+BA_W: {cmd, addr, bank} from scheduler
- sch_issue in 1: push request
- isu_fifo_full out 1: FIFO full, back-pressure to scheduler
- dram_cmd out 3: issued command (sch_cmd_t), NOP when idle
- dram_addr out ADDR_W: issued address
- dram_bank out BA_W: issued bank
- dram_cmd_valid out 1: high in cycles carrying a non-NOP command
- bank_open out 1: bank currently activated
- proto_err out 1: sticky, illegal command dropped
- ovf_err out 1: sticky, push attempted while full

Behaviour:
- Reset: clk and rst_n are already decided; reset is rst_n, synchronous, active-low, on clock clk. Reset clears FIFO (count=0), all timers=0, bank_open=0, FSM=CLOSED, dram_cmd=NOP, dram_addr=0, dram_bank=0, dram_cmd_valid=0, proto_err=0, ovf_err=0. Reset mid-operation discards queued entries and in-flight timers.
- Push: when sch_issue=1 and count<DEPTH, the word is written at the clock edge.
- Push while full: word dropped, ovf_err set. isu_fifo_full is (count==DEPTH) from registered count only, with no combinational path from pop.
- Simultaneous push and pop: count unchanged. Allowed when full, but isu_fifo_full stays 1 for that cycle.
- Pop decision is combinational on the head entry; outputs are registered. Minimum latency: push at edge k, dram_cmd visible after edge k+1.
- Timers: one 8-bit down-counter per constraint. On issue of command X at edge k, each constraint starting at X loads T-1 and decrements to 0, saturating. A command gated by T may therefore appear no earlier than k+T.
- Gate per head command:
  - ACTIVE: needs tRP, tRFC, and bank closed.
  - READ: needs tRCD, tCCD, tWTR, tRFC, and bank open.
  - WRITE: needs tRCD, tCCD, tRTW, tRFC, and bank open.
  - PRECHARGE: needs tRAS, tRTP, tWTP, tRFC. PRE while closed is legal: it is issued and no state changes.
  - REFRESH: needs tRP, tRFC, and bank closed.
- Head blocked by timing: head stays and dram_cmd=NOP. No reordering; strictly in-order.
- FSM:
  - CLOSED -ACT-> OPEN
  - OPEN -PRE-> CLOSED
  - CLOSED -REF-> REFRESHING
  - REFRESHING -> CLOSED when the tRFC counter reaches 0
  - While REFRESHING, nothing pops.
- Illegal head (READ/WRITE while CLOSED, ACT or REF while OPEN): popped without issue, proto_err set, timers untouched. A NOP head is popped silently.
- Pointers wrap modulo DEPTH.
- bank_open mirrors FSM==OPEN, registered.

Decomposition:
- usertype package (existing) holds sch_cmd_t, with encodings ATCMD_NOP/ACTIVE/READ/WRITE/PRECHARGE/REFRESH unchanged.
- Add issuer_state_t {ISS_CLOSED, ISS_OPEN, ISS_REFRESHING} to the package.
- ISU_FIFO_WIDTH from define.sv.
- One sub-module: isu_sync_fifo (parameterised DEPTH/WIDTH, push/pop/full/empty/count).

Test Plan:
- Default parameters throughout.
- ACT at issue edge k, then READ queued immediately -> READ appears on dram_cmd exactly at cycle k+4, NOP in k+1..k+3.
- ACT, WRITE, PRE back-to-back in FIFO -> PRE issues at max(ACT+10, WRITE+8). WRITE at k+4 gives PRE at k+12.
- Push 9 words with no pops (bank in REFRESHING) -> isu_fifo_full=1 after the 8th push, ovf_err=1 after the 9th, count stays 8.
- READ with bank closed -> entry consumed, proto_err=1, dram_cmd stays NOP, the next queued ACT issues the following cycle.
- REFRESH from closed at edge k, ACT queued -> ACT at k+30, and FSM passes REFRESHING->CLOSED->OPEN.
- Assert rst_n=0 for one cycle with 5 entries queued and the tRAS timer running -> next cycle all outputs at reset values, and a fresh ACT issues 2 cycles after its push.
